// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-return states, owner encoding,
// default widths and the helper that maps a granted access to its read-return state.
package dmem_arb_pkg;

    localparam int DEF_ADDRESS_LINE  = 8;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_DATA_MEM_SIZE = 256;
    localparam int DEF_STARVE_LIMIT  = 4;

    typedef enum logic [2:0] {
        R_NONE      = 3'd0,
        R_CORE      = 3'd1,
        R_EXT       = 3'd2,
        R_ZERO_CORE = 3'd3,
        R_ZERO_EXT  = 3'd4
    } rret_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    // Out-of-range reads still return a beat, but it carries zero instead of memory data.
    function automatic rret_state_e next_ret_state(input owner_e owner,
                                                   input logic   is_read,
                                                   input logic   in_range);
        rret_state_e st;
        st = R_NONE;
        if (is_read) begin
            case (owner)
                OWN_CORE: st = in_range ? R_CORE : R_ZERO_CORE;
                OWN_EXT:  st = in_range ? R_EXT  : R_ZERO_EXT;
                default:  st = R_NONE;
            endcase
        end else begin
            st = R_NONE;
        end
        return st;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for the ext port; o_sat flags that ext has waited
// LIMIT consecutive cycles and must win the next contended cycle.
module dmem_arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    logic [CNT_W-1:0] r_count;

    // Count losing cycles, hold at the limit, clear when ext is served or withdraws.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_sat) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_sat = (r_count == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and the ext requester.
// Optional fairness for the ext port is enabled by defining DMEM_ARB_FAIR_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_LINE  = DEF_ADDRESS_LINE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DATA_MEM_SIZE = DEF_DATA_MEM_SIZE,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    core_req,
    input  logic                    core_we,
    input  logic [ADDRESS_LINE-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    output logic                    core_stall,
    output logic                    core_rvalid,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    input  logic                    ext_valid,
    output logic                    ext_ready,
    input  logic                    ext_we,
    input  logic [ADDRESS_LINE-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0]   ext_wdata,
    output logic                    ext_rvalid,
    output logic [DATA_WIDTH-1:0]   ext_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDRESS_LINE-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    // One extra bit so a size equal to 2**ADDRESS_LINE is representable.
    localparam logic [ADDRESS_LINE:0] MEM_LIMIT = (ADDRESS_LINE + 1)'(DATA_MEM_SIZE);

    logic                    w_core_grant;
    logic                    w_ext_grant;
    logic                    w_starve_sat;
    owner_e                  w_owner;
    logic [ADDRESS_LINE-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0]   w_win_wdata;
    logic                    w_win_we;
    logic                    w_win_oor;
    rret_state_e             r_rstate;
    rret_state_e             w_rstate_nxt;

`ifdef DMEM_ARB_FAIR_EN
    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock (clock),
        .reset (reset),
        .i_inc (ext_valid & ~w_ext_grant),
        .i_clr (~ext_valid | w_ext_grant),
        .o_sat (w_starve_sat)
    );
`else
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT != 0);
    assign w_starve_sat   = 1'b0;
`endif

    // Pick at most one owner; core wins unless a starved ext request claims the cycle.
    always_comb begin
        w_core_grant = 1'b0;
        w_ext_grant  = 1'b0;
        w_owner      = OWN_NONE;
        if (!reset) begin
            w_owner = OWN_NONE;
        end else if (ext_valid && (!core_req || w_starve_sat)) begin
            w_ext_grant = 1'b1;
            w_owner     = OWN_EXT;
        end else if (core_req) begin
            w_core_grant = 1'b1;
            w_owner      = OWN_CORE;
        end else begin
            w_owner = OWN_NONE;
        end
    end

    // Route the winner's request fields toward the memory.
    always_comb begin
        w_win_addr  = '0;
        w_win_wdata = '0;
        w_win_we    = 1'b0;
        case (w_owner)
            OWN_CORE: begin
                w_win_addr  = core_addr;
                w_win_wdata = core_wdata;
                w_win_we    = core_we;
            end
            OWN_EXT: begin
                w_win_addr  = ext_addr;
                w_win_wdata = ext_wdata;
                w_win_we    = ext_we;
            end
            default: begin
                w_win_addr  = '0;
                w_win_wdata = '0;
                w_win_we    = 1'b0;
            end
        endcase
    end

    assign w_win_oor  = ({1'b0, w_win_addr} >= MEM_LIMIT);
    assign mem_en     = (w_owner != OWN_NONE) && !w_win_oor;
    assign mem_we     = mem_en && w_win_we;
    assign mem_addr   = w_win_addr;
    assign mem_wdata  = w_win_wdata;
    assign core_stall = reset && core_req && !w_core_grant;
    assign ext_ready  = w_ext_grant;

    // Read-return state register; reset drops any pending return beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rstate <= R_NONE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Next read-return state from this cycle's granted access.
    always_comb begin
        w_rstate_nxt = R_NONE;
        w_rstate_nxt = next_ret_state(w_owner, !w_win_we, !w_win_oor);
    end

    // Steer the returning read beat to the port that issued it.
    always_comb begin
        core_rvalid = 1'b0;
        ext_rvalid  = 1'b0;
        core_rdata  = '0;
        ext_rdata   = '0;
        if (reset) begin
            case (r_rstate)
                R_CORE: begin
                    core_rvalid = 1'b1;
                    core_rdata  = mem_rdata;
                end
                R_EXT: begin
                    ext_rvalid = 1'b1;
                    ext_rdata  = mem_rdata;
                end
                R_ZERO_CORE: core_rvalid = 1'b1;
                R_ZERO_EXT:  ext_rvalid  = 1'b1;
                default: begin
                    core_rvalid = 1'b0;
                    ext_rvalid  = 1'b0;
                end
            endcase
        end else begin
            core_rvalid = 1'b0;
            ext_rvalid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural memory sits on the mem_* side and
// expected read-return beats are queued when requests are driven, popped one cycle later.
module tb_dmem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int MSZ = 128;
    localparam int LIM = 4;

    typedef struct packed {
        logic          cv;
        logic          ev;
        logic [DW-1:0] d;
    } ret_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          core_req, core_we, core_stall, core_rvalid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          ext_valid, ext_ready, ext_we, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    ret_t          sb [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_ext_ready;
    int            n_stall;
    int            starve = 0;
    logic          last_eg = 1'b0;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDRESS_LINE (AW),
        .DATA_WIDTH   (DW),
        .DATA_MEM_SIZE(MSZ),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Behavioural single-port memory with one-cycle read latency.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_ret();
        ret_t e;
        if (sb.size() == 0) begin
            check_eq("sb_depth", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check_eq("core_rvalid", core_rvalid, e.cv);
            check_eq("ext_rvalid",  ext_rvalid,  e.ev);
            check_eq("core_rdata",  core_rdata,  e.cv ? e.d : 8'h00);
            check_eq("ext_rdata",   ext_rdata,   e.ev ? e.d : 8'h00);
        end
    endtask

    // One clock cycle: drive, predict, check at negedge, queue the expected return.
    task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic ev, input logic ew, input logic [7:0] ea, input logic [7:0] ed);
        logic       cg, eg, oor, wwe;
        logic [7:0] wa;
        ret_t       nx;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        ext_valid = ev; ext_we = ew; ext_addr = ea; ext_wdata = ed;
`ifdef DMEM_ARB_FAIR_EN
        eg = ev && (!cr || starve == LIM);
`else
        eg = ev && !cr;
`endif
        cg  = cr && !eg;
        wa  = eg ? ea : ca;
        wwe = eg ? ew : cw;
        oor = (int'(wa) >= MSZ);
        @(negedge clock);
        check_eq("core_stall", core_stall, cr && !cg);
        check_eq("ext_ready",  ext_ready,  eg);
        check_eq("mem_en",     mem_en,     (cg || eg) && !oor);
        check_eq("mem_we",     mem_we,     (cg || eg) && !oor && wwe);
        if (cg || eg) check_eq("mem_addr", mem_addr, wa);
        check_ret();
        n_ext_ready += int'(ext_ready);
        n_stall     += int'(core_stall);
        nx = '0;
        if ((cg || eg) && !wwe) begin
            nx.cv = cg;
            nx.ev = eg;
            nx.d  = oor ? 8'h00 : ref_mem[wa];
        end else if ((cg || eg) && !oor) begin
            ref_mem[wa] = eg ? ed : cd;
        end
        sb.push_back(nx);
        if (!ev || eg)        starve = 0;
        else if (starve < LIM) starve++;
        last_eg = eg;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic       pv, pwe;
        logic [7:0] pa, pd;
        int         n_cyc, exp_ext;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;

        // Reset with both requesters active: everything must stay quiet.
        reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10; core_wdata = 8'h00;
        ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 8'h11; ext_wdata = 8'h77;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_stall",  core_stall, 1'b0);
        check_eq("rst_ready",  ext_ready,  1'b0);
        check_eq("rst_mem_en", mem_en,     1'b0);
        check_eq("rst_mem_we", mem_we,     1'b0);
        check_eq("rst_rvalid", {core_rvalid, ext_rvalid}, 2'b00);
        check_eq("rst_rdata",  {core_rdata, ext_rdata}, 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.push_back('0);

        // Core read, ext idle.
        step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();

        // Same-address write conflict: core first, then ext retries and lands last.
        step(1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b1, 8'h20, 8'h99);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h99);
        step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();
        check_eq("mem20", mem[8'h20], 8'h99);

        // Out-of-range reads from both ports return zero.
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00);
        step(1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 8'h90, 8'hEE, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();

        // Back-to-back reads alternate ports with no bubbles.
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        step(1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        idle();

        // Sustained contention: fair build rotates in ext every LIM+1 cycles.
`ifdef DMEM_ARB_FAIR_EN
        n_cyc = 2 * (LIM + 1); exp_ext = 2;
`else
        n_cyc = 20; exp_ext = 0;
`endif
        n_ext_ready = 0; n_stall = 0;
        for (int i = 0; i < n_cyc; i++)
            step(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h06, 8'h00);
        check_eq("contend_ext_wins",  n_ext_ready, exp_ext);
        check_eq("contend_stalls",    n_stall,     exp_ext);
        idle();

        // Reset lands right after an ext read is accepted: its beat is never delivered.
        core_req = 1'b0; ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
        @(negedge clock);
        check_ret();
        check_eq("rr_ready", ext_ready, 1'b1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("rr_rvalid", {core_rvalid, ext_rvalid}, 2'b00);
        check_eq("rr_rdata",  {core_rdata, ext_rdata}, 16'h0000);
        @(negedge clock);
        check_eq("rr_hold_ready",  ext_ready,  1'b0);
        check_eq("rr_hold_mem_en", mem_en,     1'b0);
        check_eq("rr_hold_rvalid", ext_rvalid, 1'b0);
        @(posedge clock);
        #1;
        ext_valid = 1'b0;
        reset = 1'b1;
        sb.delete();
        sb.push_back('0);
        starve = 0;
        last_eg = 1'b0;

        // Random traffic, keeping an unaccepted ext request stable.
        pv = 1'b0; pwe = 1'b0; pa = 8'h00; pd = 8'h00;
        for (int i = 0; i < 60; i++) begin
            if (!pv || last_eg) begin
                pv  = 1'($urandom_range(0, 1));
                pwe = 1'($urandom_range(0, 1));
                pa  = 8'($urandom_range(0, 255));
                pd  = 8'($urandom);
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom), pv, pwe, pa, pd);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
